stepper_motion_ctrl: RTL and testbench

Motion controller that sequences a half-step stepper phase driver.
- Accepts move commands (step count, direction, cruise period) over a valid/ready handshake.
- Emits one-cycle step strobes with a linear accel/cruise/decel period profile.
- Drives coil enable and direction, tracks absolute position, and holds the coils energised briefly after each move.
- Sits between the host command logic and the phase sequencer, which advances one half-step per strobe.

---
 rtl/stepper_motion_ctrl_if.sv | 25 ++
 rtl/stepper_motion_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stepper_motion_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_motion_ctrl_if.sv
// Move-command channel between host logic and the stepper motion controller.
// The host drives valid/steps/dir/period; the controller returns ready.
interface stepper_motion_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [31:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_motion_ctrl.sv
// Half-step motion controller: linear accel/cruise/decel strobe profile, position tracking, coil hold.
// First strobe START_PERIOD clocks after accept; cmd_ready only while idle, so one move is in flight at a time.
module stepper_motion_ctrl #(
    parameter int unsigned START_PERIOD = 200000,
    parameter int unsigned MIN_PERIOD   = 50000,
    parameter int unsigned RAMP_DEC     = 5000,
    parameter int unsigned HOLD_CYCLES  = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    stepper_motion_ctrl_if.slave cmd,
    input  logic                 abort,
    output logic                 step_pulse,
    output logic                 dir,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic signed [31:0]   position
);
    localparam logic [31:0] START_P = 32'(START_PERIOD);
    localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
    localparam logic [31:0] RAMP_P  = 32'(RAMP_DEC);
    localparam logic [31:0] HOLD_P  = 32'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [31:0]        cur_period_q, cur_period_d;
    logic [31:0]        target_q, target_d;
    logic [31:0]        hold_q, hold_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [15:0]        ramp_q, ramp_d;
    logic               step_pulse_q, step_pulse_d;
    logic               dir_q, dir_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic signed [31:0] position_q, position_d;

    logic [31:0] cmd_target;
    logic [31:0] period_up;
    logic [31:0] period_dn;
    logic [32:0] up_sum;
    logic [32:0] dn_floor;
    logic [15:0] rem_after;
    logic [15:0] ramp_inc;
    logic [15:0] abort_rem;
    logic        strobe;

    // Ramp arithmetic is done one bit wider so neither saturation can wrap.
    always_comb begin
        cmd_target = cmd.cmd_period;
        if (cmd.cmd_period < MIN_P) begin
            cmd_target = MIN_P;
        end else if (cmd.cmd_period > START_P) begin
            cmd_target = START_P;
        end
        up_sum    = {1'b0, cur_period_q} + {1'b0, RAMP_P};
        period_up = (up_sum >= {1'b0, START_P}) ? START_P : up_sum[31:0];
        dn_floor  = {1'b0, target_q} + {1'b0, RAMP_P};
        period_dn = ({1'b0, cur_period_q} <= dn_floor) ? target_q : (cur_period_q - RAMP_P);
        rem_after = remaining_q - 16'd1;
        ramp_inc  = ramp_q + 16'd1;
        abort_rem = (ramp_q == 16'd0) ? 16'd1 :
                    ((remaining_q < ramp_q) ? remaining_q : ramp_q);
        strobe    = (timer_q == cur_period_q - 32'd1);
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cur_period_d = cur_period_q;
        target_d     = target_q;
        hold_d       = hold_q;
        remaining_d  = remaining_q;
        ramp_d       = ramp_q;
        step_pulse_d = 1'b0;
        dir_d        = dir_q;
        en_d         = en_q;
        done_d       = 1'b0;
        position_d   = position_q;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_d        = cmd.cmd_dir;
                    remaining_d  = cmd.cmd_steps;
                    target_d     = cmd_target;
                    cur_period_d = START_P;
                    timer_d      = '0;
                    ramp_d       = '0;
                    if (cmd.cmd_steps == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        en_d    = 1'b1;
                        state_d = (cmd_target == START_P) ? CRUISE : ACCEL;
                    end
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (strobe) begin
                    step_pulse_d = 1'b1;
                    timer_d      = '0;
                    remaining_d  = rem_after;
                    position_d   = dir_q ? (position_q + 32'sd1) : (position_q - 32'sd1);
                    if (rem_after == 16'd0) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end else if (state_q == ACCEL) begin
                        ramp_d = ramp_inc;
                        // Short moves turn around before reaching the cruise rate.
                        if (rem_after <= ramp_inc) begin
                            state_d      = DECEL;
                            cur_period_d = period_up;
                        end else begin
                            cur_period_d = period_dn;
                            if (period_dn == target_q) begin
                                state_d = CRUISE;
                            end
                        end
                    end else if (state_q == CRUISE) begin
                        if (rem_after <= ramp_q) begin
                            state_d      = DECEL;
                            cur_period_d = period_up;
                        end
                    end else begin
                        cur_period_d = period_up;
                    end
                end else if (abort && (state_q != DECEL)) begin
                    // Controlled stop: retrace the ramp already climbed, at least one step.
                    state_d      = DECEL;
                    remaining_d  = abort_rem;
                    cur_period_d = period_up;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_P - 32'd1) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cur_period_q <= START_P;
            target_q     <= START_P;
            hold_q       <= '0;
            remaining_q  <= '0;
            ramp_q       <= '0;
            step_pulse_q <= 1'b0;
            dir_q        <= 1'b0;
            en_q         <= 1'b0;
            done_q       <= 1'b0;
            position_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cur_period_q <= cur_period_d;
            target_q     <= target_d;
            hold_q       <= hold_d;
            remaining_q  <= remaining_d;
            ramp_q       <= ramp_d;
            step_pulse_q <= step_pulse_d;
            dir_q        <= dir_d;
            en_q         <= en_d;
            done_q       <= done_d;
            position_q   <= position_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign step_pulse    = step_pulse_q;
    assign dir           = dir_q;
    assign en            = en_q;
    assign done          = done_q;
    assign position      = position_q;
endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Bench for stepper_motion_ctrl: step-level reference model feeds a scoreboard; a negedge monitor
// pops and compares every strobe/done, plus per-cycle en/busy/ready windows and directed profiles.
`timescale 1ns/1ps
module tb_stepper_motion_ctrl;
    localparam int SP = 20;
    localparam int MP = 4;
    localparam int RD = 5;
    localparam int HC = 8;
    localparam int PH_ACCEL  = 1;
    localparam int PH_CRUISE = 2;
    localparam int PH_DECEL  = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               abort;
    logic               step_pulse;
    logic               dir;
    logic               en;
    logic               busy;
    logic               done;
    logic signed [31:0] position;

    stepper_motion_ctrl_if ifc ();

    stepper_motion_ctrl #(
        .START_PERIOD(SP),
        .MIN_PERIOD  (MP),
        .RAMP_DEC    (RD),
        .HOLD_CYCLES (HC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (ifc.slave),
        .abort     (abort),
        .step_pulse(step_pulse),
        .dir       (dir),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   edge_n;
        int   pos;
        logic sdir;
    } strobe_t;

    strobe_t strobe_q[$];
    int      done_q[$];
    int      done_pos_q[$];
    int      strobe_log[$];
    int      done_log[$];
    int      exp_iv[$];
    int      edge_cnt  = 0;
    int      n_checks  = 0;
    int      n_fail    = 0;
    int      win_lo    = 0;
    int      win_hi    = 0;
    int      model_pos = 0;
    int      last_done = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int slower(input int p);
        return (p + RD > SP) ? SP : p + RD;
    endfunction

    function automatic int faster(input int p, input int tgt);
        return (p - RD < tgt) ? tgt : p - RD;
    endfunction

    // Step-level reference: walks the move one half-step at a time using the profile rules.
    task automatic model_move(input int acc, input int steps, input bit d, input int per, input int abort_off);
        int      tgt, cur, rem, ramp, t, tn, ph;
        strobe_t s;
        tgt = (per < MP) ? MP : ((per > SP) ? SP : per);
        if (steps == 0) begin
            done_q.push_back(acc);
            done_pos_q.push_back(model_pos);
            win_lo    = acc;
            win_hi    = acc;
            last_done = acc;
            return;
        end
        cur  = SP;
        rem  = steps;
        ramp = 0;
        t    = 0;
        ph   = (tgt == SP) ? PH_CRUISE : PH_ACCEL;
        while (rem > 0) begin
            tn = t + cur;
            if (ph != PH_DECEL && abort_off > t && abort_off < tn) begin
                rem = (ramp == 0) ? 1 : ((rem < ramp) ? rem : ramp);
                cur = slower(cur);
                ph  = PH_DECEL;
                t   = abort_off;
                continue;
            end
            t = tn;
            rem--;
            model_pos += d ? 1 : -1;
            s.edge_n = acc + t;
            s.pos    = model_pos;
            s.sdir   = d;
            strobe_q.push_back(s);
            if (rem == 0) break;
            if (ph == PH_ACCEL) begin
                ramp++;
                if (rem <= ramp) begin
                    ph  = PH_DECEL;
                    cur = slower(cur);
                end else begin
                    cur = faster(cur, tgt);
                    if (cur == tgt) ph = PH_CRUISE;
                end
            end else if (ph == PH_CRUISE) begin
                if (rem <= ramp) begin
                    ph  = PH_DECEL;
                    cur = slower(cur);
                end
            end else begin
                cur = slower(cur);
            end
        end
        done_q.push_back(acc + t + HC);
        done_pos_q.push_back(model_pos);
        win_lo    = acc;
        win_hi    = acc + t + HC;
        last_done = acc + t + HC;
    endtask

    // Monitor: samples on the falling edge, after the DUT's registered outputs have settled.
    always @(negedge clock) begin
        bit      in_win;
        strobe_t s;
        int      de, dp;
        in_win = (edge_cnt >= win_lo) && (edge_cnt < win_hi);
        chk("en_window", en, in_win);
        chk("busy_window", busy, in_win);
        chk("ready_window", ifc.cmd_ready, !in_win);
        while (strobe_q.size() > 0 && strobe_q[0].edge_n < edge_cnt) begin
            chk("missed_strobe_edge", edge_cnt, strobe_q[0].edge_n);
            void'(strobe_q.pop_front());
        end
        while (done_q.size() > 0 && done_q[0] < edge_cnt) begin
            chk("missed_done_edge", edge_cnt, done_q[0]);
            void'(done_q.pop_front());
            void'(done_pos_q.pop_front());
        end
        if (step_pulse) begin
            strobe_log.push_back(edge_cnt);
            if (strobe_q.size() == 0) begin
                chk("unexpected_strobe_edge", edge_cnt, -1);
            end else begin
                s = strobe_q.pop_front();
                chk("strobe_edge", edge_cnt, s.edge_n);
                chk("strobe_position", position, s.pos);
                chk("strobe_dir", dir, s.sdir);
            end
        end
        if (done) begin
            done_log.push_back(edge_cnt);
            if (done_q.size() == 0) begin
                chk("unexpected_done_edge", edge_cnt, -1);
            end else begin
                de = done_q.pop_front();
                dp = done_pos_q.pop_front();
                chk("done_edge", edge_cnt, de);
                chk("done_position", position, dp);
            end
        end
    end

    // Issue one command from a falling edge; optionally pulse abort and wait for completion.
    task automatic issue(input int steps, input bit d, input int per, input int abort_off,
                         input bit wait_done, input bit back2back, output int acc);
        int budget;
        acc            = -1;
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_steps  = 16'(steps);
        ifc.cmd_dir    = d;
        ifc.cmd_period = 32'(per);
        budget = 0;
        while (!ifc.cmd_ready && budget < 5000) begin
            @(negedge clock);
            budget++;
        end
        if (!ifc.cmd_ready) begin
            chk("accept_timeout_cycles", budget, -1);
            ifc.cmd_valid = 1'b0;
            return;
        end
        acc = edge_cnt + 1;
        if (back2back) chk("accept_after_done_edge", acc, last_done + 1);
        model_move(acc, steps, d, per, abort_off);
        @(negedge clock);
        ifc.cmd_valid = 1'b0;
        while ((wait_done && edge_cnt < last_done) || (abort_off > 0 && edge_cnt <= acc + abort_off)) begin
            abort = (abort_off > 0) && (edge_cnt + 1 == acc + abort_off);
            @(negedge clock);
        end
        abort = 1'b0;
    endtask

    task automatic check_log(input string name, input int base, input int n_expect);
        int prev;
        chk({name, "_strobe_count"}, strobe_log.size(), n_expect);
        prev = base;
        for (int i = 0; i < exp_iv.size() && i < strobe_log.size(); i++) begin
            chk({name, "_interval"}, strobe_log[i] - prev, exp_iv[i]);
            prev = strobe_log[i];
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc2, pos0, st, pr, ab;
        bit dd;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_steps  = '0;
        ifc.cmd_dir    = 1'b0;
        ifc.cmd_period = '0;
        abort          = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_step_pulse", step_pulse, 0);
        chk("rst_dir", dir, 0);
        chk("rst_done", done, 0);
        chk("rst_position", position, 0);
        chk("rst_cmd_ready", ifc.cmd_ready, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);

        // Reset in the middle of a move discards it.
        issue(50, 1'b1, 10, 0, 1'b0, 1'b0, acc);
        repeat (60) @(negedge clock);
        @(posedge clock);
        #2;
        strobe_q.delete();
        done_q.delete();
        done_pos_q.delete();
        win_lo    = 0;
        win_hi    = 0;
        model_pos = 0;
        reset     = 1'b0;
        @(negedge clock);
        chk("midrst_position", position, 0);
        chk("midrst_step_pulse", step_pulse, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        repeat (40) @(negedge clock);
        chk("post_release_position", position, 0);
        chk("post_release_dir", dir, 0);

        // Zero-step command.
        strobe_log.delete();
        done_log.delete();
        issue(0, 1'b1, 10, 0, 1'b1, 1'b0, acc);
        repeat (5) @(negedge clock);
        chk("t2_done_count", done_log.size(), 1);
        if (done_log.size() > 0) chk("t2_done_edge", done_log[0], acc);
        chk("t2_strobe_count", strobe_log.size(), 0);

        // Full trapezoid.
        strobe_log.delete();
        done_log.delete();
        issue(10, 1'b1, 10, 0, 1'b1, 1'b0, acc);
        exp_iv = '{20, 15, 10, 10, 10, 10, 10, 10, 15, 20};
        check_log("t3", acc, 10);
        if (done_log.size() > 0 && strobe_log.size() > 0)
            chk("t3_hold_cycles", done_log[0] - strobe_log[strobe_log.size() - 1], HC);
        chk("t3_position", position, 10);

        // Triangle: target never reached.
        strobe_log.delete();
        done_log.delete();
        issue(3, 1'b1, 4, 0, 1'b1, 1'b0, acc);
        exp_iv = '{20, 15, 20};
        check_log("t4", acc, 3);
        chk("t4_position", position, 13);

        // Abort 3 cycles after the 4th strobe (offsets 20+15+10+10+3).
        strobe_log.delete();
        done_log.delete();
        pos0 = 13;
        issue(100, 1'b0, 10, 58, 1'b1, 1'b0, acc);
        chk("t5_strobe_count", strobe_log.size(), 6);
        if (strobe_log.size() == 6) begin
            chk("t5_after_abort", strobe_log[4] - (acc + 58), 15);
            chk("t5_final_interval", strobe_log[5] - strobe_log[4], 20);
        end
        chk("t5_position_delta", position - pos0, -6);

        // Clamp low: reaches MIN_PERIOD.
        strobe_log.delete();
        issue(12, 1'b1, 1, 0, 1'b1, 1'b0, acc);
        exp_iv = '{20, 15, 10, 5, 4, 4, 4, 4, 9, 14, 19, 20};
        check_log("t6_low", acc, 12);

        // Clamp high plus back-to-back acceptance with valid held.
        strobe_log.delete();
        issue(3, 1'b1, 1000, 0, 1'b0, 1'b0, acc);
        issue(4, 1'b0, 7, 0, 1'b1, 1'b1, acc2);
        exp_iv = '{20, 20, 20};
        check_log("t6_high", acc, 7);
        chk("t6_position", position, 18);

        // Randomized moves with occasional aborts.
        for (int i = 0; i < 20; i++) begin
            st = $urandom_range(0, 30);
            dd = 1'($urandom_range(0, 1));
            pr = $urandom_range(0, 30);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 400) : 0;
            issue(st, dd, pr, ab, 1'b1, 1'b0, acc);
        end

        repeat (20) @(negedge clock);
        chk("pending_strobes", strobe_q.size(), 0);
        chk("pending_dones", done_q.size(), 0);
        chk("final_position", position, model_pos);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
